// File: rtl/branch_predictor.sv
// Fetch-side BTB/BHT branch predictor with EX-stage resolution,
// training, mispredict redirect and saturating statistics.
module branch_predictor #(
  parameter int ENTRIES = 64,
  localparam int IDX_W = $clog2(ENTRIES),
  localparam int TAG_W = 30 - IDX_W
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_f_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        upd_valid_i,
  input  logic        upd_is_br_i,
  input  logic [31:0] upd_pc_i,
  input  logic [31:0] upd_target_i,
  input  logic [2:0]  upd_funct3_i,
  output logic        BrUn_o,
  input  logic        BrEq_i,
  input  logic        BrLt_i,
  input  logic        upd_pred_taken_i,
  input  logic [31:0] upd_pred_target_i,
  output logic        br_taken_o,
  output logic        mispredict_o,
  output logic [31:0] redirect_pc_o,
  input  logic        flush_i,
  output logic [31:0] stat_br_o,
  output logic [31:0] stat_miss_o
);

  logic [ENTRIES-1:0] validQ;
  logic [TAG_W-1:0]   tagQ [ENTRIES];
  logic [31:0]        tgtQ [ENTRIES];
  logic [1:0]         ctrQ [ENTRIES];

  logic [31:0] statBr;
  logic [31:0] statMiss;

  logic [IDX_W-1:0] fIdx;
  logic [TAG_W-1:0] fTag;
  logic             fHit;

  logic [IDX_W-1:0] uIdx;
  logic [TAG_W-1:0] uTag;
  logic             uHit;
  logic [1:0]       uCtr;
  logic [1:0]       uCtrNext;

  logic isEq;
  logic isNe;
  logic isLt;
  logic isGe;
  logic legal;
  logic cond;
  logic brValid;
  logic res;
  logic taken;
  logic tgtWrong;

  // pc[1:0] never participates in indexing or tagging
  logic unusedBits;
  assign unusedBits = ^{pc_f_i[1:0], upd_pc_i[1:0]};

  assign fIdx = pc_f_i[IDX_W+1:2];
  assign fTag = pc_f_i[31:IDX_W+2];
  assign fHit = validQ[fIdx] && (tagQ[fIdx] == fTag);

  assign pred_taken_o  = fHit & ctrQ[fIdx][1];
  assign pred_target_o = pred_taken_o ? tgtQ[fIdx]
                                      : pc_f_i + 32'd4;

  assign BrUn_o = upd_funct3_i[1];

  assign isEq = (upd_funct3_i == 3'b000);
  assign isNe = (upd_funct3_i == 3'b001);
  assign isLt = (upd_funct3_i == 3'b100)
              | (upd_funct3_i == 3'b110);
  assign isGe = (upd_funct3_i == 3'b101)
              | (upd_funct3_i == 3'b111);

  always_comb begin
    legal = 1'b1;
    cond  = 1'b0;
    unique case (1'b1)
      isEq:    cond = BrEq_i;
      isNe:    cond = ~BrEq_i;
      isLt:    cond = BrLt_i;
      isGe:    cond = ~BrLt_i;
      default: legal = 1'b0;
    endcase
  end

  assign brValid = upd_valid_i & upd_is_br_i;
  assign res     = brValid & legal;
  assign taken   = res & cond;

  assign br_taken_o = taken;

  assign tgtWrong = upd_pred_target_i != upd_target_i;

  assign mispredict_o = res
    & ((upd_pred_taken_i != taken) | (taken & tgtWrong));

  assign redirect_pc_o = taken ? upd_target_i
                               : upd_pc_i + 32'd4;

  assign uIdx = upd_pc_i[IDX_W+1:2];
  assign uTag = upd_pc_i[31:IDX_W+2];
  assign uHit = validQ[uIdx] && (tagQ[uIdx] == uTag);
  assign uCtr = ctrQ[uIdx];

  always_comb begin
    uCtrNext = uCtr;
    if (taken) begin
      if (uCtr != 2'b11) uCtrNext = uCtr + 2'd1;
    end else begin
      if (uCtr != 2'b00) uCtrNext = uCtr - 2'd1;
    end
  end

  // flush only drops valid bits and wins over a same-cycle update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      validQ <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tagQ[i] <= '0;
        tgtQ[i] <= '0;
        ctrQ[i] <= '0;
      end
    end else if (flush_i) begin
      validQ <= '0;
    end else if (res) begin
      if (uHit) begin
        ctrQ[uIdx] <= uCtrNext;
        if (taken) tgtQ[uIdx] <= upd_target_i;
      end else begin
        validQ[uIdx] <= 1'b1;
        tagQ[uIdx]   <= uTag;
        tgtQ[uIdx]   <= upd_target_i;
        ctrQ[uIdx]   <= taken ? 2'b10 : 2'b01;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      statBr   <= '0;
      statMiss <= '0;
    end else begin
      if (res && (statBr != '1))
        statBr <= statBr + 32'd1;
      if (mispredict_o && (statMiss != '1))
        statMiss <= statMiss + 32'd1;
    end
  end

  assign stat_br_o   = statBr;
  assign stat_miss_o = statMiss;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized scoreboard bench for branch_predictor against a
// table-level reference model of the predictor.
module tb_branch_predictor;

  localparam int N  = 64;
  localparam int IW = 6;

  logic        clk;
  logic        rst_ni;
  logic [31:0] pc_f_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i;
  logic        upd_is_br_i;
  logic [31:0] upd_pc_i;
  logic [31:0] upd_target_i;
  logic [2:0]  upd_funct3_i;
  logic        BrUn_o;
  logic        BrEq_i;
  logic        BrLt_i;
  logic        upd_pred_taken_i;
  logic [31:0] upd_pred_target_i;
  logic        br_taken_o;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic        flush_i;
  logic [31:0] stat_br_o;
  logic [31:0] stat_miss_o;

  branch_predictor #(.ENTRIES(N)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .pc_f_i            (pc_f_i),
    .pred_taken_o      (pred_taken_o),
    .pred_target_o     (pred_target_o),
    .upd_valid_i       (upd_valid_i),
    .upd_is_br_i       (upd_is_br_i),
    .upd_pc_i          (upd_pc_i),
    .upd_target_i      (upd_target_i),
    .upd_funct3_i      (upd_funct3_i),
    .BrUn_o            (BrUn_o),
    .BrEq_i            (BrEq_i),
    .BrLt_i            (BrLt_i),
    .upd_pred_taken_i  (upd_pred_taken_i),
    .upd_pred_target_i (upd_pred_target_i),
    .br_taken_o        (br_taken_o),
    .mispredict_o      (mispredict_o),
    .redirect_pc_o     (redirect_pc_o),
    .flush_i           (flush_i),
    .stat_br_o         (stat_br_o),
    .stat_miss_o       (stat_miss_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        predTaken;
    bit [31:0] predTarget;
    bit        brUn;
    bit        brTaken;
    bit        mis;
    bit [31:0] redirect;
    bit [31:0] statBr;
    bit [31:0] statMiss;
    string     name;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // reference model: per-entry state and counters as plain ints
  bit        mValid [N];
  bit [31:0] mTag   [N];
  bit [31:0] mTgt   [N];
  int        mCtr   [N];
  bit [31:0] mStatBr;
  bit [31:0] mStatMiss;

  function automatic int idxOf(input bit [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic bit [31:0] tagOf(input bit [31:0] pc);
    return pc >> (IW + 2);
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < N; i++) begin
      mValid[i] = 0;
      mTag[i] = 0;
      mTgt[i] = 0;
      mCtr[i] = 0;
    end
    mStatBr = 0;
    mStatMiss = 0;
  endfunction

  function automatic bit modelHit(input bit [31:0] pc);
    int i = idxOf(pc);
    return mValid[i] && (mTag[i] == tagOf(pc));
  endfunction

  function automatic void modelPredict(
    input bit [31:0] pc, output bit tk, output bit [31:0] tg);
    int i = idxOf(pc);
    tk = modelHit(pc) && (mCtr[i] >= 2);
    tg = tk ? mTgt[i] : pc + 4;
  endfunction

  // branch semantics straight from the operands
  function automatic void resolve(
    input bit [2:0] f3, input bit [31:0] a, input bit [31:0] b,
    output bit legal, output bit cond);
    legal = 1;
    cond = 0;
    case (f3)
      3'd0: cond = (a == b);
      3'd1: cond = (a != b);
      3'd4: cond = ($signed(a) < $signed(b));
      3'd5: cond = ($signed(a) >= $signed(b));
      3'd6: cond = (a < b);
      3'd7: cond = (a >= b);
      default: legal = 0;
    endcase
  endfunction

  task automatic chk(input string nm, input bit [31:0] act,
                     input bit [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic doCycle(
    input bit [31:0] fpc, input bit v, input bit isBr,
    input bit [31:0] upc, input bit [31:0] utgt,
    input bit [2:0] f3, input bit [31:0] a, input bit [31:0] b,
    input bit pT, input bit [31:0] pTg, input bit fl,
    input string nm);
    exp_t e;
    bit legal, cond, tk, res;
    int ui;
    pc_f_i = fpc;
    upd_valid_i = v;
    upd_is_br_i = isBr;
    upd_pc_i = upc;
    upd_target_i = utgt;
    upd_funct3_i = f3;
    BrEq_i = (a == b);
    BrLt_i = f3[1] ? (a < b) : ($signed(a) < $signed(b));
    upd_pred_taken_i = pT;
    upd_pred_target_i = pTg;
    flush_i = fl;
    modelPredict(fpc, e.predTaken, e.predTarget);
    resolve(f3, a, b, legal, cond);
    res = v && isBr && legal;
    tk = res && cond;
    e.brUn = f3[1];
    e.brTaken = tk;
    e.mis = res && ((pT != tk) || (tk && pTg != utgt));
    e.redirect = tk ? utgt : upc + 4;
    e.statBr = mStatBr;
    e.statMiss = mStatMiss;
    e.name = nm;
    q.push_back(e);
    if (rst_ni) begin
      if (res && mStatBr != 32'hFFFF_FFFF) mStatBr++;
      if (e.mis && mStatMiss != 32'hFFFF_FFFF) mStatMiss++;
      ui = idxOf(upc);
      if (fl) begin
        for (int i = 0; i < N; i++) mValid[i] = 0;
      end else if (res) begin
        if (modelHit(upc)) begin
          mCtr[ui] = tk ? ((mCtr[ui] + 1 > 3) ? 3 : mCtr[ui] + 1)
                        : ((mCtr[ui] - 1 < 0) ? 0 : mCtr[ui] - 1);
          if (tk) mTgt[ui] = utgt;
        end else begin
          mValid[ui] = 1;
          mTag[ui] = tagOf(upc);
          mTgt[ui] = utgt;
          mCtr[ui] = tk ? 2 : 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // monitor: every cycle with an issued stimulus is checked mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.name, ".predTaken"}, 32'(pred_taken_o), 32'(e.predTaken));
        chk({e.name, ".predTarget"}, pred_target_o, e.predTarget);
        chk({e.name, ".brUn"}, 32'(BrUn_o), 32'(e.brUn));
        chk({e.name, ".brTaken"}, 32'(br_taken_o), 32'(e.brTaken));
        chk({e.name, ".mispredict"}, 32'(mispredict_o), 32'(e.mis));
        chk({e.name, ".redirect"}, redirect_pc_o, e.redirect);
        chk({e.name, ".statBr"}, stat_br_o, e.statBr);
        chk({e.name, ".statMiss"}, stat_miss_o, e.statMiss);
      end
    end
  end

  function automatic bit [31:0] randPc();
    bit [31:0] t = $urandom_range(0, 3);
    bit [31:0] i = $urandom_range(0, 7);
    bit [31:0] lo = $urandom_range(0, 3);
    return (t << 12) | (i << 2) | lo | 32'h100;
  endfunction

  function automatic bit [31:0] randOp();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return 32'd5;
    endcase
  endfunction

  initial begin
    bit pT;
    bit [31:0] pTg;
    bit [31:0] upc;
    int waitCnt;
    rst_ni = 0;
    pc_f_i = 0;
    upd_valid_i = 0;
    upd_is_br_i = 0;
    upd_pc_i = 0;
    upd_target_i = 0;
    upd_funct3_i = 0;
    BrEq_i = 0;
    BrLt_i = 0;
    upd_pred_taken_i = 0;
    upd_pred_target_i = 0;
    flush_i = 0;
    modelReset();
    #12 rst_ni = 1;
    @(posedge clk);
    #1;

    doCycle(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
    doCycle(32'h100, 1, 1, 32'h100, 32'h180, 3'd0, 7, 7,
            0, 32'h104, 0, "beqTrain");
    doCycle(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "beqLookup");

    for (int k = 0; k < 3; k++)
      doCycle(32'h100, 1, 1, 32'h100, 32'h180, 3'd6, 10, 3,
              1, 32'h180, 0, "bltuNt");
    doCycle(32'h100, 1, 1, 32'h100, 32'h180, 3'd6, 1, 2,
            0, 32'h104, 0, "bltuTk");
    doCycle(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "weakNt");

    doCycle(32'h100, 1, 1, 32'h100 + 4 * N, 32'h240, 3'd0, 1, 1,
            0, 32'h204, 0, "alias");
    doCycle(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "aliasMiss");

    doCycle(32'h200, 1, 1, 32'h300, 32'h380, 3'd1, 1, 2,
            0, 32'h304, 1, "flushUpd");
    doCycle(32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "flushMissA");
    doCycle(32'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "flushMissB");

    for (int k = 0; k < 600; k++) begin
      upc = randPc();
      modelPredict(upc, pT, pTg);
      if ($urandom_range(0, 7) == 0) pT = ~pT;
      if ($urandom_range(0, 7) == 0) pTg = pTg ^ 32'h40;
      if (k == 300) begin
        rst_ni = 0;
        modelReset();
        doCycle(randPc(), 1, 1, upc, 32'h4000, 3'd0, 1, 1,
                pT, pTg, 0, "midReset");
        rst_ni = 1;
      end else begin
        doCycle(randPc(), $urandom_range(0, 7) != 0,
                $urandom_range(0, 3) != 0, upc,
                32'h4000 + 32'($urandom_range(0, 3)) * 32'h40,
                3'($urandom_range(0, 7)), randOp(), randOp(),
                pT, pTg, $urandom_range(0, 49) == 0, "rand");
      end
    end

    force dut.statBr = 32'hFFFF_FFFE;
    force dut.statMiss = 32'hFFFF_FFFE;
    #1;
    release dut.statBr;
    release dut.statMiss;
    mStatBr = 32'hFFFF_FFFE;
    mStatMiss = 32'hFFFF_FFFE;
    for (int k = 0; k < 3; k++)
      doCycle(32'h500, 1, 1, 32'h500, 32'h580, 3'd0, 3, 3,
              0, 32'h504, 0, "statSat");

    waitCnt = 0;
    while (q.size() > 0 && waitCnt < 20) begin
      @(posedge clk);
      waitCnt++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
